// File: rtl/uart_prog_loader_pkg.sv
// Shared constants, state encodings and helpers for the UART program loader.
package uart_prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CSUM, S_DONE, S_ERR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  // Drops one byte into its little-endian lane of a 32-bit word.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver (uart_rx_8n1) and, when UART_PROG_LOADER_ACK_EN is defined,
// the matching transmitter (uart_tx_8n1). rst_n is an active-high synchronous reset.
module uart_rx_8n1 import uart_prog_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           rx_meta, rx_sync, valid_n, ferr_n;

  // NOTE: registers take only non-blocking updates; every next value is computed in always_comb.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = RX_START;
      end
      RX_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
        // A glitch shorter than half a bit falls back to idle.
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n     = '0;
        shreg_n   = {rx_sync, shreg[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = RX_STOP;
      end
      RX_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n   = '0;
        state_n = RX_IDLE;
        valid_n = rx_sync;
        ferr_n  = !rx_sync;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data = shreg;

endmodule

`ifdef UART_PROG_LOADER_ACK_EN
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [9:0]    shreg;
  logic [3:0]    bits_left;
  logic [CW-1:0] cnt;

  // A start request while a byte is in flight is ignored, never aborts it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg     <= '1;
      bits_left <= '0;
      cnt       <= '0;
    end else if (bits_left == 4'd0) begin
      if (start) begin
        shreg     <= {1'b1, data, 1'b0};
        bits_left <= 4'd10;
        cnt       <= '0;
      end
    end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
      cnt       <= '0;
      shreg     <= {1'b1, shreg[9:1]};
      bits_left <= bits_left - 4'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tx = shreg[0];

endmodule
`endif

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a checksummed image and writes it into instruction memory.
// Define UART_PROG_LOADER_ACK_EN to add uart_tx with an ACK/NAK reply. rst_n is active-high.
module uart_prog_loader import uart_prog_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 6,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   words_loaded
`ifdef UART_PROG_LOADER_ACK_EN
  ,
  output logic              uart_tx
`endif
);
  localparam int NW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  load_state_e       state, state_n;
  logic [NW-1:0]     n_words, n_words_n, wl_n;
  logic [1:0]        byte_idx, byte_idx_n, err_n;
  logic [31:0]       asm_word, asm_n, wdata_n;
  logic [7:0]        csum, csum_n, rx_data;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              we_n, hold_n, busy_n, done_n, rx_valid, rx_ferr;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_valid (rx_valid),
    .data       (rx_data),
    .frame_err  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= S_IDLE;
      n_words      <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
      csum         <= '0;
      to_cnt       <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      n_words      <= n_words_n;
      byte_idx     <= byte_idx_n;
      asm_word     <= asm_n;
      csum         <= csum_n;
      to_cnt       <= to_cnt_n;
      im_we        <= we_n;
      im_addr      <= addr_n;
      im_wdata     <= wdata_n;
      cpu_hold     <= hold_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      words_loaded <= wl_n;
    end
  end

  always_comb begin
    state_n    = state;
    n_words_n  = n_words;
    byte_idx_n = byte_idx;
    asm_n      = asm_word;
    csum_n     = csum;
    to_cnt_n   = '0;
    we_n       = 1'b0;
    addr_n     = im_addr;
    wdata_n    = im_wdata;
    hold_n     = cpu_hold;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
    wl_n       = words_loaded;

    // Advance only after a write that was not the last word, so the address never wraps.
    if (im_we && state == S_DATA) addr_n = im_addr + ADDR_W'(1);

    if (state inside {S_COUNT, S_DATA, S_CSUM}) begin
      to_cnt_n = to_cnt + TW'(1);
      if (rx_valid) begin
        to_cnt_n = '0;
        case (state)
          S_COUNT: begin
            n_words_n = (rx_data == 8'd0) ? NW'(1 << ADDR_W) : NW'(rx_data);
            state_n   = S_DATA;
          end
          S_DATA: begin
            asm_n      = place_byte(asm_word, byte_idx, rx_data);
            csum_n     = csum + rx_data;
            byte_idx_n = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we_n    = 1'b1;
              wdata_n = asm_n;
              wl_n    = words_loaded + NW'(1);
              if (wl_n == n_words) state_n = S_CSUM;
            end
          end
          default: begin
            busy_n = 1'b0;
            if (rx_data == csum) begin
              state_n = S_DONE;
              done_n  = 1'b1;
              hold_n  = 1'b0;
            end else begin
              state_n = S_ERR;
              err_n   = ERR_CSUM;
            end
          end
        endcase
      end else if (rx_ferr) begin
        state_n = S_ERR;
        err_n   = ERR_FRAME;
        busy_n  = 1'b0;
      end else if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
        state_n = S_ERR;
        err_n   = ERR_TIMEOUT;
        busy_n  = 1'b0;
      end
    end else if (rx_valid && rx_data == SYNC_BYTE) begin
      state_n    = S_COUNT;
      hold_n     = 1'b1;
      busy_n     = 1'b1;
      done_n     = 1'b0;
      err_n      = ERR_NONE;
      wl_n       = '0;
      addr_n     = '0;
      byte_idx_n = '0;
      csum_n     = '0;
    end
  end

`ifdef UART_PROG_LOADER_ACK_EN
  logic tx_start;
  assign tx_start = (state_n != state) && (state_n inside {S_DONE, S_ERR});

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  ((state_n == S_DONE) ? ACK_BYTE : NAK_BYTE),
    .tx    (uart_tx)
  );
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: frame table plus hand-written error/corner sequences.
// Define UART_PROG_LOADER_ACK_EN to also check the ACK/NAK reply on uart_tx.
module tb_uart_prog_loader;
  localparam int CPB = 8;

  typedef struct {
    logic [7:0]  n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    logic        exp_done;
    logic [1:0]  exp_err;
    logic [6:0]  exp_wl;
    logic        exp_hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold, busy, done;
  logic [1:0]  err;
  logic [6:0]  words_loaded;
`ifdef UART_PROG_LOADER_ACK_EN
  logic        uart_tx;
  logic [7:0]  tx_log [16];
  int          tx_cnt = 0;
`endif

  logic [31:0] mem [64];
  int          we_cnt = 0;
  logic [5:0]  last_addr = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(6), .TIMEOUT_CLKS(500)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
`ifdef UART_PROG_LOADER_ACK_EN
    ,
    .uart_tx      (uart_tx)
`endif
  );

  always #5 clk = ~clk;

  // Instruction-memory model fed by the write strobe.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      mem[im_addr] = im_wdata;
      we_cnt       = we_cnt + 1;
      last_addr    = im_addr;
    end
  end

`ifdef UART_PROG_LOADER_ACK_EN
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx_cnt < 16) tx_log[tx_cnt] = b;
      tx_cnt = tx_cnt + 1;
    end
  end
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(8'hA5, 1'b1);
    send_byte(v.n, 1'b1);
    send_word(v.w0);
    if (v.n == 8'd2) send_word(v.w1);
    send_byte(v.csum, 1'b1);
  endtask

  vec_t vecs [6];

  initial begin
    int base;
    logic [7:0] k;

    vecs[0] = '{8'd2, 32'h00000013, 32'h00100093, 8'hB6, 1'b1, 2'd0, 7'd2, 1'b0};
    vecs[1] = '{8'd2, 32'h00000013, 32'h00100093, 8'hB7, 1'b0, 2'd3, 7'd2, 1'b1};
    vecs[2] = '{8'd2, 32'h00000013, 32'h00100093, 8'hB6, 1'b1, 2'd0, 7'd2, 1'b0};
    vecs[3] = '{8'd1, 32'h04030201, 32'h0,        8'h0A, 1'b1, 2'd0, 7'd1, 1'b0};
    vecs[4] = '{8'd1, 32'hFFFFFFFF, 32'h0,        8'hFC, 1'b1, 2'd0, 7'd1, 1'b0};
    vecs[5] = '{8'd1, 32'h12345678, 32'h0,        8'h14, 1'b1, 2'd0, 7'd1, 1'b0};

    rst_n   = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs", {im_we, im_addr, im_wdata, cpu_hold, busy, done, err, words_loaded}, 32'h0);
    check("reset_wdata", im_wdata, 32'h0);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base = we_cnt;
      send_frame(vecs[i]);
      repeat (100) @(negedge clk);
      check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_words_loaded", i), words_loaded, vecs[i].exp_wl);
      check($sformatf("v%0d_cpu_hold", i), cpu_hold, vecs[i].exp_hold);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      check($sformatf("v%0d_we_count", i), we_cnt - base, vecs[i].n);
      check($sformatf("v%0d_mem0", i), mem[0], vecs[i].w0);
      if (vecs[i].n == 8'd2) check($sformatf("v%0d_mem1", i), mem[1], vecs[i].w1);
`ifdef UART_PROG_LOADER_ACK_EN
      check($sformatf("v%0d_tx_byte", i), tx_log[i], vecs[i].exp_done ? 32'h06 : 32'h15);
`endif
    end

    // Noise before sync is ignored; then a framing error on the third data byte.
    send_byte(8'h55, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("noise_cpu_hold", cpu_hold, 1'b0);
    check("noise_done_kept", done, 1'b1);
    base = we_cnt;
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("sync_cpu_hold", cpu_hold, 1'b1);
    check("sync_busy", busy, 1'b1);
    check("sync_done_cleared", done, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_code", err, 2'd1);
    check("frame_err_busy", busy, 1'b0);
    check("frame_err_hold", cpu_hold, 1'b1);
    check("frame_err_no_we", we_cnt - base, 0);

    // Idle gap longer than the timeout after two data bytes.
    base = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (600) @(negedge clk);
    check("timeout_err_code", err, 2'd2);
    check("timeout_busy", busy, 1'b0);
    check("timeout_hold", cpu_hold, 1'b1);
    check("timeout_no_we", we_cnt - base, 0);

    // Full 64-word image via count byte 0; data byte k has value k, checksum 0x80.
    base = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int j = 0; j < 256; j++) begin
      k = j[7:0];
      send_byte(k, 1'b1);
    end
    send_byte(8'h80, 1'b1);
    repeat (100) @(negedge clk);
    check("full_we_count", we_cnt - base, 64);
    check("full_last_addr", last_addr, 6'd63);
    check("full_words_loaded", words_loaded, 7'd64);
    check("full_done", done, 1'b1);
    check("full_err", err, 2'd0);
    check("full_mem0_no_wrap", mem[0], 32'h03020100);
    check("full_mem63", mem[63], 32'hFFFEFDFC);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check("midframe_hold", cpu_hold, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", {im_we, im_addr, cpu_hold, busy, done, err, words_loaded}, 32'h0);
`ifdef UART_PROG_LOADER_ACK_EN
    repeat (100) @(negedge clk);
    check("tx_idle_high", uart_tx, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
